// File: rtl/vga_fb_arbiter.sv
// Shares one single-port cell RAM between beam prefetch (one cell ahead) and a write FIFO; pix/syncs lag xpos/ypos by 1 clk.
// Writer is backpressured via wr_ready=!full; optional VGA_FB_WR_BLANK_ONLY_EN restricts RAM writes to vertical blanking.

module vga_fb_wr_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_FULL = DEPTH[AW:0];

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (push_vld) r_wptr <= r_wptr + AW'(1);
            if (pop_vld)  r_rptr <= r_rptr + AW'(1);
            case ({push_vld, pop_vld})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld) r_mem[r_wptr] <= push_dat;
    end

    assign pop_dat = r_mem[r_rptr];
    assign full    = (r_cnt == LP_FULL);
    assign empty   = (r_cnt == '0);
endmodule

module vga_fb_arbiter #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  xpos,
    input  logic [9:0]  ypos,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  pix,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [12:0] wr_addr,
    input  logic [2:0]  wr_data,
    output logic [12:0] ram_addr,
    output logic        ram_we,
    output logic [2:0]  ram_wdata,
    input  logic [2:0]  ram_rdata
);
    typedef struct packed {
        logic [12:0] addr;
        logic [2:0]  data;
    } wr_ent_t;

    localparam logic [9:0] LP_H_FETCH = 10'(H_TOTAL - 4);
    localparam logic [9:0] LP_H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] LP_V_LAST  = 10'(V_TOTAL - 1);

    logic       r_vslot_d;
    logic [2:0] r_nxt;
    logic [2:0] r_cur;
    logic [2:0] r_pix;
    logic       r_hsync;
    logic       r_vsync;

    logic       w_line_slot;
    logic       w_eol_slot;
    logic       w_vslot;
    logic       w_wslot;
    logic       w_cur_ld;
    logic [5:0] w_fetch_row;
    logic [6:0] w_fetch_col;
    logic [12:0] w_fetch_addr;
    logic       w_full;
    logic       w_empty;
    logic       w_push;
    logic       w_pop;
    wr_ent_t    w_head;
    wr_ent_t    w_in;

    assign w_line_slot = (xpos[2:0] == 3'd4) && (xpos < 10'd632);
    assign w_eol_slot  = (xpos == LP_H_FETCH);
    assign w_vslot     = w_line_slot || w_eol_slot;
    assign w_cur_ld    = ((xpos[2:0] == 3'd7) && (xpos < 10'd632)) || (xpos == LP_H_LAST);

    // End-of-line fetch pulls column 0 of the next line's row, wrapping at frame end.
    assign w_fetch_row = !w_eol_slot          ? ypos[8:3] :
                         (ypos == LP_V_LAST)  ? 6'd0      :
                         6'((ypos[8:0] + 9'd1) >> 3);
    assign w_fetch_col  = w_eol_slot ? 7'd0 : (xpos[9:3] + 7'd1);
    assign w_fetch_addr = 13'({w_fetch_row, 6'b0}) + 13'({w_fetch_row, 4'b0}) + 13'(w_fetch_col);

`ifdef VGA_FB_WR_BLANK_ONLY_EN
    assign w_wslot = !w_vslot && (ypos >= 10'd480);
`else
    assign w_wslot = !w_vslot;
`endif

    assign w_pop    = w_wslot && !w_empty;
    assign w_push   = wr_valid && !w_full;
    assign wr_ready = !w_full;
    assign w_in     = '{addr: wr_addr, data: wr_data};

    vga_fb_wr_fifo #(
        .W     ($bits(wr_ent_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (w_push),
        .push_dat (w_in),
        .pop_vld  (w_pop),
        .pop_dat  (w_head),
        .full     (w_full),
        .empty    (w_empty)
    );

    // Out-of-range heads are popped without touching the RAM.
    always_comb begin
        ram_addr  = 13'd0;
        ram_we    = 1'b0;
        ram_wdata = 3'd0;
        if (w_vslot) begin
            ram_addr = w_fetch_addr;
        end else if (w_pop && (w_head.addr < 13'd4800)) begin
            ram_addr  = w_head.addr;
            ram_we    = 1'b1;
            ram_wdata = w_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vslot_d <= 1'b0;
            r_nxt     <= 3'd0;
            r_cur     <= 3'd0;
            r_pix     <= 3'd0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
        end else begin
            r_vslot_d <= w_vslot;
            if (r_vslot_d) r_nxt <= ram_rdata;
            if (w_cur_ld)  r_cur <= r_nxt;
            r_pix   <= ((xpos < 10'd640) && (ypos < 10'd480)) ? r_cur : 3'd0;
            r_hsync <= hsync_in;
            r_vsync <= vsync_in;
        end
    end

    assign pix   = r_pix;
    assign hsync = r_hsync;
    assign vsync = r_vsync;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: drives the beam itself, models the RAM, scoreboards writes.
module tb_vga_fb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  xpos = '0;
    logic [9:0]  ypos = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        hsync;
    logic        vsync;
    logic [2:0]  pix;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [12:0] wr_addr = '0;
    logic [2:0]  wr_data = '0;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [2:0]  ram_wdata;
    logic [2:0]  ram_rdata;

    logic [2:0]  mem [0:8191];
    logic [15:0] exp_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          ok;

    vga_fb_arbiter #(.H_TOTAL(800), .V_TOTAL(525), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hsync(hsync), .vsync(vsync), .pix(pix),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] exp_fetch(input int x, input int y);
        int row;
        int col;
        if (x == 796) begin
            row = (y == 524) ? 0 : (((y + 1) >> 3) & 63);
            col = 0;
        end else begin
            row = (y >> 3) & 63;
            col = (x >> 3) + 1;
        end
        return 13'(row * 80 + col);
    endfunction

    task automatic upd_sync();
        hsync_in = !(xpos >= 10'd656 && xpos < 10'd752);
        vsync_in = !(ypos == 10'd490 || ypos == 10'd491);
    endtask

    task automatic set_beam(input int x, input int y);
        xpos = 10'(x);
        ypos = 10'(y);
        upd_sync();
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        if (xpos == 10'd799) begin
            xpos = '0;
            ypos = (ypos == 10'd524) ? 10'd0 : ypos + 10'd1;
        end else begin
            xpos = xpos + 10'd1;
        end
        upd_sync();
        #1;
    endtask

    task automatic push(input logic [12:0] a, input logic [2:0] d, input int bound, output bit acc_ok);
        bit acc;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        acc_ok   = 1'b0;
        for (int i = 0; i < bound; i++) begin
            acc = wr_ready;
            advance();
            if (acc) begin
                acc_ok = 1'b1;
                if (a < 13'd4800) exp_q.push_back({a, d});
                break;
            end
        end
    endtask

    // Every video slot must be a read of the next cell; every write must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (((xpos % 8) == 4 && xpos < 10'd632) || xpos == 10'd796) begin
                chk("vid_we", 32'(ram_we), 0);
                chk("vid_addr", 32'(ram_addr), 32'(exp_fetch(xpos, ypos)));
            end else if (ram_we) begin
                if (exp_q.size() == 0) begin
                    chk("we_spurious", 32'(ram_we), 0);
                end else begin
                    chk("wr_ent", 32'({ram_addr, ram_wdata}), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                end
`ifdef VGA_FB_WR_BLANK_ONLY_EN
                chk("wr_blank", 32'(ypos >= 10'd480), 1);
`endif
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        chk("rst_pix", 32'(pix), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hsync_in = 1'b1;
        vsync_in = 1'b1;
        #1;
        chk("rel_wr_ready", 32'(wr_ready), 1);
        chk("rel_ram_we", 32'(ram_we), 0);

        // Preload cells during vertical blanking.
        set_beam(0, 500);
        push(13'd0,  3'b100, 8, ok); chk("push_c0",  32'(ok), 1);
        push(13'd1,  3'b010, 8, ok); chk("push_c1",  32'(ok), 1);
        push(13'd79, 3'b111, 8, ok); chk("push_c79", 32'(ok), 1);
        wr_valid = 1'b0;
        repeat (10) advance();
        chk("preload_drain", 32'(exp_q.size()), 0);

        set_beam(790, 524);
        for (int i = 0; i < 20 && !(xpos == 0 && ypos == 0); i++) advance();
        for (int k = 0; k < 16; k++) begin
            advance();
            chk("pix_line0", 32'(pix), (k < 8) ? 32'h4 : 32'h2);
        end
        for (int i = 0; i < 800 && xpos != 10'd640; i++) advance();
        chk("pix_col639", 32'(pix), 7);
        advance();
        chk("pix_col640_blank", 32'(pix), 0);
        for (int i = 0; i < 800 && xpos != 10'd656; i++) advance();
        chk("hsync_pre", 32'(hsync), 1);
        advance();
        chk("hsync_pulse", 32'(hsync), 0);
        set_beam(799, 489);
        advance();
        chk("vsync_pre", 32'(vsync), 1);
        advance();
        chk("vsync_pulse", 32'(vsync), 0);

        // Six back-to-back writes on an active line.
        set_beam(0, 100);
`ifndef VGA_FB_WR_BLANK_ONLY_EN
        for (int i = 0; i < 6; i++) begin
            push(13'(100 + i), 3'(i + 1), 1, ok);
            chk("b2b_accept", 32'(ok), 1);
        end
        wr_valid = 1'b0;
`else
        for (int i = 0; i < 4; i++) begin
            push(13'(100 + i), 3'(i + 1), 1, ok);
            chk("fill_accept", 32'(ok), 1);
        end
        chk("full_rdy", 32'(wr_ready), 0);
        wr_valid = 1'b1;
        wr_addr  = 13'd104;
        wr_data  = 3'd5;
        repeat (20) advance();
        chk("stall_rdy", 32'(wr_ready), 0);
        chk("stall_q", 32'(exp_q.size()), 4);
        wr_valid = 1'b0;
        set_beam(8, 480);
        chk("blank_we0", 32'(ram_we), 1);
        advance();
        chk("blank_we1", 32'(ram_we), 1);
        push(13'd104, 3'd5, 4, ok); chk("blank_push5", 32'(ok), 1);
        push(13'd105, 3'd6, 4, ok); chk("blank_push6", 32'(ok), 1);
        wr_valid = 1'b0;
`endif
        repeat (12) advance();
        chk("b2b_drain", 32'(exp_q.size()), 0);
        for (int i = 0; i < 6; i++) chk("b2b_mem", 32'(mem[100 + i]), 32'(i + 1));

        // Out-of-range entry must be dropped silently.
        set_beam(0, 500);
        push(13'd4800, 3'b011, 4, ok); chk("push_oob", 32'(ok), 1);
        chk("drop_we", 32'(ram_we), 0);
        push(13'd5, 3'b101, 4, ok);    chk("push_a5", 32'(ok), 1);
        wr_valid = 1'b0;
        repeat (8) advance();
        chk("drop_drain", 32'(exp_q.size()), 0);
        chk("mem_a5", 32'(mem[5]), 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Arbitrates a single-port 3-bit-per-cell framebuffer RAM between VGA scan-out and a pixel writer. The display is 640x480 divided into 80x60 cells of 8x8 pixels. The block sits between `vga_sync` (`xpos`, `ypos`, syncs on the pixel clock) and the top-level colour pins. It prefetches one cell ahead of the beam and drains a small write FIFO into the RAM during every cycle scan-out does not need.

## Interface
Parameters:
- `H_TOTAL`, 800: pixel clocks per line, matching `vga_sync`.
- `V_TOTAL`, 525: lines per frame.
- `FIFO_DEPTH`, 4: write FIFO entries; power of two, ≥2.

Ports:
- `clk` in 1: pixel clock (`vga_clk` domain); the block has one clock.
- `rst` in 1: reset, synchronous, active-high.
- `xpos` in 10: beam column from `vga_sync`.
- `ypos` in 10: beam line from `vga_sync`.
- `hsync_in` in 1: raw hsync from `vga_sync`.
- `vsync_in` in 1: raw vsync from `vga_sync`.
- `hsync` out 1: hsync delayed to align with `pix`.
- `vsync` out 1: vsync delayed to align with `pix`.
- `pix` out 3: colour; bit2=G, bit1=R, bit0=B.
- `wr_valid` in 1: writer offers an entry.
- `wr_ready` out 1: FIFO can accept the entry.
- `wr_addr` in 13: cell address, row*80+col.
- `wr_data` in 3: cell colour.
- `ram_addr` out 13: RAM address.
- `ram_we` out 1: RAM write enable.
- `ram_wdata` out 3: RAM write data.
- `ram_rdata` in 3: RAM read data; valid the cycle after address presentation (1-cycle read latency).

## Operation
- Cell coordinates: col = `xpos[9:3]`, row = `ypos[8:3]`. Address = row*64 + row*16 + col, 13 bits, maximum 4799.
- Video slot: a cycle where (`xpos[2:0]`==4 and `xpos`<632) or `xpos`==H_TOTAL-4.
  - Drive `ram_we`=0.
  - Drive `ram_addr` = next cell: col+1 on the current row, or, at H_TOTAL-4, col 0 of row (`ypos`+1)[8:3].
  - At `ypos`==V_TOTAL-1 the next row is 0. Rows ≥60 fetch harmlessly and their data is never displayed.
- Next cycle after a video slot: `nxt` <= `ram_rdata`.
- `cur` <= `nxt` when (`xpos[2:0]`==7 and `xpos`<632) or `xpos`==H_TOTAL-1.
- `pix` <= (`xpos`<640 and `ypos`<480) ? `cur` : 3'b000.
- Writer slot: any cycle that is not a video slot (gated further by the macro below).
  - If the FIFO is non-empty: pop the head.
  - If head addr < 4800: drive `ram_we`=1, `ram_addr`=head addr, `ram_wdata`=head data.
  - If head addr ≥4800: pop the entry and discard it, with `ram_we`=0.
- Idle cycle (neither slot active): `ram_we`=0, `ram_addr`=0.
- `ram_addr`, `ram_we` and `ram_wdata` are combinational from `xpos`, `ypos` and the FIFO head.
- FIFO:
  - `wr_ready` = !full, registered-state based.
  - Push when `wr_valid` and `wr_ready`.
  - When full, `wr_ready`=0 even in a pop cycle.
  - Push and pop in the same cycle keep the count unchanged.
  - Entries are written to RAM in push order.
- `hsync`/`vsync` <= `hsync_in`/`vsync_in`, one register stage.

## Timing
- Reset (synchronous):
  - `pix`=0, `cur`=0, `nxt`=0.
  - `hsync`=1, `vsync`=1.
  - FIFO empty; `wr_ready`=1 the cycle after reset deasserts.
- Reset mid-line: the first frame after reset may show stale cells until the first H_TOTAL-4 fetch. No recovery logic is required.
- Output latency: `pix`, `hsync` and `vsync` at cycle t+1 correspond to `xpos`/`ypos` at cycle t.
- Cell boundary: the cell for columns 8k..8k+7 appears on `pix` from `xpos`=8k+1 through 8k+8, as seen at the input.
- Video reads: one per 8 clocks inside the active line, plus one per line in blanking. Writer slots therefore number at least 7 of every 8 clocks.
- Write visibility: a pushed entry reaches RAM no earlier than 1 cycle after the push, the cycle after it becomes the FIFO head. With `FIFO_DEPTH`=4 and a full FIFO, the worst case is 5 cycles in the active region.

## Configuration
- `VGA_FB_WR_BLANK_ONLY_EN`:
  - Defined: writer slots exist only when `ypos`≥480, i.e. vertical blanking, giving tear-free updates. During active lines the FIFO only fills, and `wr_ready` drops once it holds `FIFO_DEPTH` entries.
  - Undefined: every non-video cycle is a writer slot.

## Test plan
- Assert `rst` for 2 cycles, then release → `pix`=0, `hsync`=`vsync`=1 during reset; `wr_ready`=1 and `ram_we`=0 after release.
- Preload cells 0=3'b100 and 1=3'b010, then run to line 0 → `pix`=3'b100 for input `xpos` 0..7 and 3'b010 for `xpos` 8..15, each observed one cycle later.
- Push 6 writes back-to-back with the FIFO drained only in writer slots → `wr_ready` falls after 4 entries if the FIFO cannot drain, and all 6 land in RAM in order. `ram_we` is never 1 when `xpos[2:0]`==4 and `xpos`<632.
- Push `wr_addr`=4800 followed by `wr_addr`=5 → the first is dropped with no `ram_we`, and the second writes address 5.
- With `VGA_FB_WR_BLANK_ONLY_EN` defined, push at `ypos`=100 → no `ram_we` until `ypos`=480, then writes issue on consecutive cycles.
